// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream bundle for the 2x2 max-pool stage.
// Carries the conv pixels in and the pooled pixels out.
interface maxpool2x2_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      output in_valid,
      output in_data,
      input  out_valid,
      input  out_data,
      input  out_last
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output out_valid,
      output out_data,
      output out_last
   );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pooling over a row-major frame.
// One line buffer holds the even-row horizontal maxima.
module maxpool2x2_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 24,
   parameter int IMG_H      = 24
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   maxpool2x2_stream_if.slave      bus,
   output logic                    busy,
   output logic                    done
);
   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int HW = IMG_W / 2;
   localparam int LW = (HW > 1) ? $clog2(HW) : 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef logic signed [DATA_WIDTH-1:0] pix_t;

   state_t state, state_nxt;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   pix_t          held;
   pix_t          linebuf [HW];

   pix_t          px, h, lb, pooled;
   logic [LW-1:0] lb_idx;
   logic          accept, col_end, row_end, frame_end;

   assign px        = $signed(bus.in_data);
   assign accept    = (state == RUN) && bus.in_valid;
   assign col_end   = (col == CW'(IMG_W - 1));
   assign row_end   = (row == RW'(IMG_H - 1));
   assign frame_end = accept && col_end && row_end;
   assign busy      = (state == RUN);

   // col is always odd when the buffer is touched, so col/2 = col[LW:1]
   assign lb_idx = col[LW:1];
   assign h      = (held > px) ? held : px;
   assign lb     = linebuf[lb_idx];
   assign pooled = (h > lb) ? h : lb;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN:  if (frame_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (state == IDLE && start) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held <= '0;
      end else if (accept && !col[0]) begin
         held <= px;
      end
   end

   // Line buffer needs no reset: every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (accept && col[0] && !row[0]) begin
         linebuf[lb_idx] <= h;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         done          <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         done          <= 1'b0;
         if (accept && col[0] && row[0]) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= pooled;
            bus.out_last  <= frame_end;
            done          <= frame_end;
         end
      end
   end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream.
// Driver queues expected pooled pixels; monitor checks them.
module tb_maxpool2x2_stream;
   localparam int DW = 8;
   localparam int W  = 24;
   localparam int H  = 24;

   typedef struct {
      int d;
      bit last;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done;

   maxpool2x2_stream_if #(.DATA_WIDTH(DW)) bus ();

   maxpool2x2_stream #(
      .DATA_WIDTH(DW),
      .IMG_W(W),
      .IMG_H(H)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .bus(bus.slave),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int checks = 0;
   int fails = 0;
   int cycle = 0;
   int n_done = 0;
   int want_done = 0;
   int last_val = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, req, cycle);
      end
   endtask

   function automatic int pix(input int kind, input int r, input int c);
      if (kind == 0) return r + c;
      return (r == 5 && c == 8) ? -1 : -128;
   endfunction

   function automatic int pooled(input int kind, input int i, input int j);
      if (kind == 0) return 2 * i + 2 * j + 2;
      return (i == 2 && j == 4) ? -1 : -128;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = q.pop_front();
               chk("out_data", int'($signed(bus.out_data)), e.d);
               chk("out_last", int'(bus.out_last), int'(e.last));
               chk("done_with_last", int'(done), int'(e.last));
               chk("latency_cycle", cycle, e.cyc);
               if (e.last) chk("busy_in_done", int'(busy), 0);
            end
            last_val = int'($signed(bus.out_data));
            if (done) n_done++;
         end else begin
            chk("out_data_hold", int'($signed(bus.out_data)), last_val);
            if (done) chk("done_without_out", 1, 0);
         end
      end
   end

   task automatic frame(input int kind, input bit gap, input bit pre,
                        input int start_at, input int abort_at,
                        input bit chain);
      int p, k, r, c;
      bit v;
      if (!pre) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("busy_run", int'(busy), 1);
      p = 0;
      k = 0;
      while (p < W * H) begin
         if (p == abort_at) return;
         v = !gap || (k % 3 == 0);
         k++;
         r = p / W;
         c = p % W;
         bus.in_valid = v;
         bus.in_data  = v ? DW'(pix(kind, r, c)) : DW'(77);
         start = (p == start_at) && v;
         if (v) begin
            if ((r % 2 == 1) && (c % 2 == 1))
               q.push_back('{pooled(kind, r / 2, c / 2),
                             p == W * H - 1, cycle + 1});
            p++;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      start = chain;
      want_done++;
      if (chain) begin
         @(posedge clk); #1;
         start = 1'b0;
      end else begin
         repeat (3) @(posedge clk);
         #1;
         chk("idle_after_frame", int'(busy), 0);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_out_last", int'(bus.out_last), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;

      // pixels offered in IDLE must be ignored
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(100);
      repeat (30) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;

      frame(0, 1'b0, 1'b0, -1, -1, 1'b0);
      frame(1, 1'b0, 1'b0, -1, -1, 1'b0);
      frame(0, 1'b1, 1'b0, -1, -1, 1'b0);
      frame(0, 1'b0, 1'b0, 100, -1, 1'b0);

      frame(0, 1'b0, 1'b0, -1, 300, 1'b0);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_out_data", int'(bus.out_data), 0);
      chk("midrst_out_last", int'(bus.out_last), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_queue_empty", q.size(), 0);
      q.delete();
      last_val = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(50);
      repeat (40) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("no_run_after_rst", int'(busy), 0);
      frame(0, 1'b0, 1'b0, -1, -1, 1'b0);

      frame(0, 1'b0, 1'b0, -1, -1, 1'b1);
      frame(0, 1'b0, 1'b1, -1, -1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      chk("done_pulses", n_done, want_done);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end
endmodule

// File: doc/maxpool2x2_stream.md
MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of signed pixel data.
REQ-002 SHALL have parameter IMG_W, default 24, input feature-map width in pixels; SHALL be even and >= 2.
REQ-003 SHALL have parameter IMG_H, default 24, input feature-map height in pixels; SHALL be even and >= 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, begins one frame when sampled high in IDLE.
REQ-007 SHALL have port in_valid, input, 1, marks in_data as a valid conv output pixel.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, signed conv pixel; frame arrives row-major.
REQ-009 SHALL have port out_valid, input-qualified output, 1, marks out_data valid.
REQ-010 SHALL have port out_data, output, DATA_WIDTH, signed pooled pixel.
REQ-011 SHALL have port out_last, output, 1, marks the final pooled pixel of the frame.
REQ-012 SHALL have port busy, output, 1, high while in RUN.
REQ-013 SHALL have port done, output, 1, one-cycle frame-complete pulse.

Function
REQ-014 SHALL implement FSM with states IDLE and RUN; IDLE->RUN when start=1; RUN->IDLE on the edge accepting pixel (IMG_H-1, IMG_W-1).
REQ-015 SHALL ignore start while in RUN; SHALL ignore in_valid while in IDLE.
REQ-016 SHALL maintain col counter (0..IMG_W-1) and row counter (0..IMG_H-1), both cleared on IDLE->RUN, advancing only on accepted pixels (RUN and in_valid=1); col wraps to 0 and row increments at col=IMG_W-1.
REQ-017 SHALL tolerate arbitrary in_valid gaps; counters, buffers and outputs hold during gaps.
REQ-018 SHALL hold the even-column pixel in a register; at odd column compute horizontal max h = max(held, in_data) using signed comparison.
REQ-019 SHALL, on even rows at odd columns, write h into a line buffer of IMG_W/2 entries at index col/2.
REQ-020 SHALL, on odd rows at odd columns, compute max(h, linebuf[col/2]) and register it to out_data with out_valid=1 the following cycle (latency exactly 1 cycle after the accepting edge).
REQ-021 SHALL hold out_valid high for exactly one cycle per pooled pixel; out_data SHALL retain its last value when out_valid=0.
REQ-022 SHALL emit exactly (IMG_W/2)*(IMG_H/2) pooled pixels per frame, in row-major pooled order.
REQ-023 SHALL assert out_last and done together, for one cycle, coincident with out_valid of the final pooled pixel; busy SHALL be 0 in that cycle.
REQ-024 SHALL, when equal values compete, output that value (tie order irrelevant); no saturation or width growth, out_data width = DATA_WIDTH.
REQ-025 SHALL accept start in the same cycle done is high (state is IDLE) and begin a new frame with counters cleared.

Reset
REQ-026 SHALL on rst_n=0, asynchronously and regardless of state, force state=IDLE, col=0, row=0, out_valid=0, out_data=0, out_last=0, done=0, busy=0.
REQ-027 SHALL not require line-buffer contents to be cleared by reset; every entry is written before read within a frame.
REQ-028 SHALL, after reset released mid-frame, discard the partial frame and await start.

Verification
REQ-029 Ramp: start, then 576 pixels in_data=row+col, in_valid continuous -> 144 outputs, first out_data=2, output(i,j)=2i+2j+2, last=46 with out_last=done=1.
REQ-030 Negative values: all pixels -128 except pixel (5,8)=-1 -> pooled (2,4)=-1, all other 143 outputs=-128.
REQ-031 Gaps: ramp frame with in_valid toggling 1,0,0 pattern -> identical 144-value sequence as REQ-029, each out_valid exactly 1 cycle after its odd-row odd-col accept.
REQ-032 Start while busy: pulse start at pixel 100 of a frame -> no counter reset, frame completes normally with 144 outputs.
REQ-033 Reset mid-frame: assert rst_n=0 after 300 pixels -> all outputs 0 immediately; in_valid without start produces no out_valid; new start plus full ramp frame -> REQ-029 results.
REQ-034 Back-to-back: start asserted in done cycle, second ramp frame follows -> second frame yields 144 correct outputs, second done pulse.
